// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative 32-step MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    input  logic              flush,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              stall
);

    localparam int W = DATA_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [4:0]     r_cnt;
    logic           r_is_div;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_dz;
    logic           r_done;

    logic           w_signed;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_abs;
    logic [W-1:0]   w_b_abs;
    logic           w_div_zero;
    logic           w_start_ok;
    logic [2*W-1:0] w_mul_acc;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
    logic           w_qbit;
    logic [2*W-1:0] w_div_acc;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_res_hi;
    logic [W-1:0]   w_res_lo;

    assign w_signed   = ~op[0];
    assign w_a_neg    = w_signed & busA[W-1];
    assign w_b_neg    = w_signed & busB[W-1];
    assign w_a_abs    = w_a_neg ? -busA : busA;
    assign w_b_abs    = w_b_neg ? -busB : busB;
    assign w_div_zero = op[1] && (busB == '0);
    assign w_start_ok = (r_state == S_IDLE) && start && !flush;

    // Multiply consumes the multiplier MSB-first: acc = 2*acc + bit*b.
    assign w_mul_acc = {r_acc[2*W-2:0], 1'b0} + (r_a[W-1] ? {{W{1'b0}}, r_b} : {(2*W){1'b0}});

    // Restoring divide: acc = {remainder, quotient}, dividend bits shifted in from r_a.
    assign w_rem_sh  = {r_acc[2*W-1:W], r_a[W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_qbit    = ~w_diff[W];
    assign w_div_acc = {(w_qbit ? w_diff[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_qbit};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_comb begin
        w_res_hi = w_prod[2*W-1:W];
        w_res_lo = w_prod[W-1:0];
        if (r_dz) begin
            w_res_hi = r_acc[2*W-1:W];
            w_res_lo = r_acc[W-1:0];
        end else if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = w_div_zero ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_is_div <= op[1];
                        r_a      <= w_a_abs;
                        r_b      <= w_b_abs;
                        r_cnt    <= '0;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= w_div_zero;
                        // Divide-by-zero preloads its final {hi, lo} so FINISH just copies it.
                        r_acc    <= w_div_zero ? {busA, {W{1'b1}}} : {(2*W){1'b0}};
                    end else if (!start) begin
                        if (wr_hi) r_hi <= wdata;
                        if (wr_lo) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 5'd1;
                        r_a   <= {r_a[W-2:0], 1'b0};
                        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                    end
                end
                S_FINISH: begin
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign stall = busy | start;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .busA  (busA),
        .busB  (busB),
        .flush (flush),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int lat);
        int bad_cycle;
        @(negedge clk);
        op = o; busA = a; busB = b; start = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL %s_stall got %b want 1", name, stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        bad_cycle = -1;
        for (int i = 0; i < lat; i++) begin
            if ((busy !== 1'b1 || done !== 1'b0) && bad_cycle < 0) bad_cycle = i;
            @(posedge clk); #1;
        end
        checks++;
        if (bad_cycle >= 0) begin
            errors++;
            $display("FAIL %s_inflight busy/done wrong at E+%0d", name, bad_cycle);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b want done=1 busy=0", name, done, busy);
        end
        checks++;
        if (hi !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi got %h want %h", name, hi, exp_hi);
        end
        checks++;
        if (lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo got %h want %h", name, lo, exp_lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got %b want 0", name, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b want all 0",
                     hi, lo, busy, done, stall);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    endtask

    task automatic test_div;
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33);
    endtask

    task automatic test_div_corner;
        run_op("divzero", 2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
        run_op("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    endtask

    task automatic test_flush;
        int seen_done;
        @(negedge clk);
        op = 2'b00; busA = 32'd3; busB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy=%b done=%b want 0 0", busy, done);
        end
        seen_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen_done = 1;
        end
        checks++;
        if (seen_done != 0 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL flush_keep got hi=%h lo=%h done_seen=%0d want hi=0 lo=80000000 none",
                     hi, lo, seen_done);
        end
        @(negedge clk);
        op = 2'b01; busA = 32'd2; busB = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_drop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midop;
        int seen_done;
        @(negedge clk);
        op = 2'b00; busA = 32'd3; busB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_nodone got activity=%0d want 0", seen_done);
        end
    endtask

    task automatic test_ctrl_writes;
        int lo_bad;
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL mthi got %h want cafebabe", hi);
        end
        @(negedge clk);
        wr_lo = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        checks++;
        if (lo !== 32'h1234_5678 || hi !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h want cafebabe 12345678", hi, lo);
        end
        @(negedge clk);
        op = 2'b01; busA = 32'd6; busB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lo_bad = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 3) begin wr_lo = 1'b1; wdata = 32'hDEAD_BEEF; end
            if (c == 4) begin start = 1'b1; op = 2'b11; busA = 32'd100; busB = 32'd0; end
            @(posedge clk); #1;
            wr_lo = 1'b0; start = 1'b0;
            if (lo !== 32'h1234_5678 || done !== 1'b0 || busy !== 1'b1) lo_bad = c;
        end
        checks++;
        if (lo_bad != 0) begin
            errors++;
            $display("FAIL busy_ignore got lo=%h busy=%b at E+%0d want 12345678 busy", lo, busy, lo_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL ctrl_result got done=%b hi=%h lo=%h want 1 0 2a", done, hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_no_restart got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_flush();
        test_reset_midop();
        test_ctrl_writes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage; consumes the ID/EX register's outputs (decoded EX control, busA/busB operand registers).
- Executes MULT, MULTU, DIV and DIVU in 32 iterations and holds results in architectural HI/LO registers.
- Drives a stall back to the front of the pipeline so the IF/ID and ID/EX registers hold while an operation is in flight.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  single-cycle request, decoded from the ID/EX EX control field
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- busA  input  32  operand A / dividend (from ID/EX busA register)
- busB  input  32  operand B / divisor (from ID/EX busB register)
- flush  input  1  abort the in-flight operation (branch/exception squash)
- wr_hi  input  1  MTHI write strobe
- wr_lo  input  1  MTLO write strobe
- wdata  input  32  MTHI/MTLO data
- hi  output  32  HI register (MFHI source)
- lo  output  32  LO register (MFLO source)
- busy  output  1  high in RUN or FINISH
- done  output  1  one-cycle pulse when hi/lo are updated by an operation
- stall  output  1  combinational: busy | start

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand/accumulator registers=0.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 at edge E:
  - Latch op, |busA| and |busB| (absolute values for signed ops, raw values for unsigned), and the result signs.
  - Clear the 64-bit accumulator, set count=0, go to RUN.
  - DIV/DIVU with busB==0: go directly to FINISH with the divide-by-zero flag set.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, E+1..E+32. On the 32nd step (count==31) go to FINISH.
- FINISH at E+33:
  - Sign-correct the results.
  - Multiply: {hi,lo} = 64-bit product; negate if operand signs differ (signed op only).
  - Divide: lo = quotient, negated if signs differ; hi = remainder, takes the sign of the dividend.
  - Pulse done=1 for one cycle, return to IDLE.
  - Total latency: start sampled at E, results visible after E+33.
- Divide by zero: done and write at E+1; hi=busA, lo=32'hFFFF_FFFF; no trap.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored, no restart. start must be a single-cycle pulse.
- flush: in RUN or FINISH, next edge goes to IDLE. hi/lo are unchanged and done stays 0. flush in IDLE has no effect. flush and start in the same IDLE cycle: flush wins, the op is dropped.
- wr_hi/wr_lo: honoured only in IDLE with start=0; hi/lo <= wdata at the edge. Ignored while busy. start in the same cycle wins and the write is dropped.
- hi/lo change only on reset, a FINISH write, or an MTHI/MTLO write.
- Reset mid-operation: immediate IDLE and all values cleared; no done pulse.
- Arithmetic: 64-bit internal accumulator; all comparisons unsigned on magnitudes.

Test Plan:
- MULT busA=0xFFFFFFFD (-3), busB=5 -> done at E+33, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=1 from E through E+32, stall=1 during start cycle.
- MULTU busA=busB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV busA=0xFFFFFFF9 (-7), busB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU busA=0x1234, busB=0 -> done at E+1, hi=0x1234, lo=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, flush at E+10 -> IDLE at E+11, no done, hi/lo keep prior values. Repeat with reset asserted at E+5 -> hi=lo=0 immediately, busy=0.
- Control writes:
  - wr_hi=1, wdata=0xCAFEBABE in IDLE -> hi=0xCAFEBABE.
  - wr_lo during RUN -> lo unchanged.
  - start asserted at E+4 while busy -> ignored, result still at E+33.
